// File: rtl/node_ctrl_pkg.sv
// Shared types and constants for the layer-node controllers.
package node_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
  localparam logic [31:0] FP_ONE     = 32'h3F80_0000;
  localparam logic [31:0] FP_NEG_ONE = 32'hBF80_0000;

endpackage

// File: rtl/fp_relu.sv
// Combinational ReLU on an IEEE-754 single: any value with the sign bit set
// (including -0.0 and negative NaN) clamps to +0.0, everything else passes.
module fp_relu
  import node_ctrl_pkg::*;
(
  input  logic [31:0] a,
  output logic [31:0] y
);

  assign y = a[31] ? FP_ZERO : a;

endmodule

// File: rtl/node_mac_sequencer.sv
// Time-multiplexed node: one shared multiplier and adder compute
// ReLU(sum A[i]*W[i]) over N_INPUTS pairs, then offer the result downstream.
module node_mac_sequencer
  import node_ctrl_pkg::*;
#(
  parameter int N_INPUTS = 15,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] act_addr,
  input  logic [31:0]       act_data,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [31:0]       w_data,
  output logic [31:0]       mul_x,
  output logic [31:0]       mul_y,
  input  logic [31:0]       mul_z,
  output logic [31:0]       add_a,
  output logic [31:0]       add_b,
  input  logic [31:0]       add_out,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_INPUTS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       acc_q, acc_d;
  logic [31:0]       prod_r_q, prod_r_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       relu_y;
  state_t            dbg_state;

  assign dbg_state = state_q;

  fp_relu u_relu (
    .a (add_out),
    .y (relu_y)
  );

  // Output handshake: out_valid stays high with out_data frozen until the
  // cycle where out_valid && out_ready, which is the single transfer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    prod_r_d    = prod_r_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    act_addr    = '0;
    mul_x       = FP_ZERO;
    mul_y       = FP_ZERO;
    add_a       = FP_ZERO;
    add_b       = FP_ZERO;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MAC;
          idx_d   = '0;
          acc_d   = FP_ZERO;
        end
      end
      MAC: begin
        act_addr = idx_q;
        mul_x    = act_data;
        mul_y    = w_data;
        prod_r_d = mul_z;
        // The product registered last cycle is accumulated one cycle late.
        if (idx_q != '0) begin
          add_a = acc_q;
          add_b = prod_r_q;
          acc_d = add_out;
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DRAIN: begin
        add_a       = acc_q;
        add_b       = prod_r_q;
        acc_d       = add_out;
        out_data_d  = relu_y;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= FP_ZERO;
      prod_r_q    <= FP_ZERO;
      out_data_q  <= FP_ZERO;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      prod_r_q    <= prod_r_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign w_addr    = act_addr;
  assign busy      = (state_q == MAC) || (state_q == DRAIN);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule
